// File: rtl/mult_fu_pipe_pkg.sv
// Shared types for the pipelined multiply FU: function codes, stage-register layout
// and operand extension helper.
package mult_fu_pipe_pkg;

  localparam int XLEN            = 64;
  localparam int NUM_PHYS_REG    = 64;
  localparam int TAG_W           = $clog2(NUM_PHYS_REG);
  localparam int MULT_NUM_STAGES = 4;

  typedef enum logic [1:0] {
    MUL_LO    = 2'd0,
    MUL_HI_SS = 2'd1,
    MUL_HI_UU = 2'd2,
    MUL_HI_SU = 2'd3
  } mult_func_t;

  typedef struct packed {
    logic              valid;
    mult_func_t        func;
    logic [TAG_W-1:0]  tag;
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] mplier;
    logic [2*XLEN-1:0] acc;
  } mult_stage_t;

  localparam mult_stage_t EMPTY_MULT_STAGE = '0;

  function automatic logic [2*XLEN-1:0] ext_op(input logic [XLEN-1:0] op, input logic sgn);
    return {{XLEN{sgn & op[XLEN-1]}}, op};
  endfunction

endpackage

// File: rtl/mult_fu_pipe_if.sv
// Issue / CDB handshake bundle between the reservation station, the multiply FU
// and the CDB arbiter.
interface mult_fu_pipe_if;
  import mult_fu_pipe_pkg::*;

  logic             issue_valid;
  logic [XLEN-1:0]  issue_opa;
  logic [XLEN-1:0]  issue_opb;
  mult_func_t       issue_func;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_stall;
  logic             cdb_gnt;
  logic             done_valid;
  logic [XLEN-1:0]  done_result;
  logic [TAG_W-1:0] done_tag;

  modport master (
    output issue_valid, issue_opa, issue_opb, issue_func, issue_tag, cdb_gnt,
    input  issue_stall, done_valid, done_result, done_tag
  );

  modport slave (
    input  issue_valid, issue_opa, issue_opb, issue_func, issue_tag, cdb_gnt,
    output issue_stall, done_valid, done_result, done_tag
  );
endinterface

// File: rtl/mult_fu_pipe_stage.sv
// One multiply stage: adds the partial products of multiplier chunk IDX into the
// running accumulator, purely combinational, modulo 2^(2*XLEN).
module mult_fu_pipe_stage #(
  parameter int XLEN  = 64,
  parameter int CHUNK = 32,
  parameter int IDX   = 0
) (
  input  logic [2*XLEN-1:0] mcand,
  input  logic [CHUNK-1:0]  mplier_chunk,
  input  logic [2*XLEN-1:0] acc_in,
  output logic [2*XLEN-1:0] acc_out
);
  localparam int BASE = IDX * CHUNK;

  logic [2*XLEN-1:0] pp [CHUNK];

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_pp
    assign pp[gi] = mplier_chunk[gi] ? (mcand << (BASE + gi)) : '0;
  end

  always_comb begin
    acc_out = acc_in;
    for (int j = 0; j < CHUNK; j++) begin
      acc_out = acc_out + pp[j];
    end
  end
endmodule

// File: rtl/mult_fu_pipe.sv
// Pipelined integer multiply FU with collapsing-bubble back-pressure and squash.
// Define MULT_FU_PERF_CNT_EN to add the granted-result and issue-stall counters.
module mult_fu_pipe
  import mult_fu_pipe_pkg::*;
#(
  parameter int NUM_STAGES = MULT_NUM_STAGES
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          squash,
  mult_fu_pipe_if.slave fu
`ifdef MULT_FU_PERF_CNT_EN
  ,
  output logic [31:0]   perf_done_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);
  localparam int CHUNK = 2 * XLEN / NUM_STAGES;

  mult_stage_t           st_reg  [NUM_STAGES];
  mult_stage_t           st_next [NUM_STAGES];
  mult_stage_t           st_src  [NUM_STAGES];
  logic [2*XLEN-1:0]     acc_sum [NUM_STAGES];
  logic [NUM_STAGES-1:0] adv;
  mult_stage_t           tail;
  logic                  issue_accept;
  logic                  sign_a;
  logic                  sign_b;

  // A stage may load whenever it is empty or its occupant moves on, so bubbles collapse.
  always_comb begin
    adv[NUM_STAGES-1] = ~st_reg[NUM_STAGES-1].valid | fu.cdb_gnt;
    for (int k = NUM_STAGES - 2; k >= 0; k--) begin
      adv[k] = ~st_reg[k].valid | adv[k+1];
    end
  end

  assign fu.issue_stall = st_reg[0].valid & ~adv[0];
  assign issue_accept   = fu.issue_valid & ~fu.issue_stall;
  assign sign_a         = (fu.issue_func == MUL_HI_SS) || (fu.issue_func == MUL_HI_SU);
  assign sign_b         = (fu.issue_func == MUL_HI_SS);

  always_comb begin
    st_src[0]        = EMPTY_MULT_STAGE;
    st_src[0].valid  = issue_accept;
    st_src[0].func   = fu.issue_func;
    st_src[0].tag    = fu.issue_tag;
    st_src[0].mcand  = ext_op(fu.issue_opa, sign_a);
    st_src[0].mplier = ext_op(fu.issue_opb, sign_b);
    for (int k = 1; k < NUM_STAGES; k++) begin
      st_src[k] = st_reg[k-1];
    end
  end

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    mult_fu_pipe_stage #(
      .XLEN (XLEN),
      .CHUNK(CHUNK),
      .IDX  (gi)
    ) u_stage (
      .mcand       (st_src[gi].mcand),
      .mplier_chunk(st_src[gi].mplier[gi*CHUNK +: CHUNK]),
      .acc_in      (st_src[gi].acc),
      .acc_out     (acc_sum[gi])
    );

    assign st_next[gi] = {st_src[gi].valid, st_src[gi].func, st_src[gi].tag,
                          st_src[gi].mcand, st_src[gi].mplier, acc_sum[gi]};
  end

  // Squash only kills valids; stale datapath contents are harmless behind valid=0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_STAGES; k++) st_reg[k] <= EMPTY_MULT_STAGE;
    end else if (squash) begin
      for (int k = 0; k < NUM_STAGES; k++) st_reg[k].valid <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (adv[k]) st_reg[k] <= st_next[k];
      end
    end
  end

  assign tail           = st_reg[NUM_STAGES-1];
  assign fu.done_valid  = tail.valid;
  assign fu.done_tag    = tail.tag;
  assign fu.done_result = (tail.func == MUL_LO) ? tail.acc[XLEN-1:0] : tail.acc[2*XLEN-1:XLEN];

`ifdef MULT_FU_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_done_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (tail.valid & fu.cdb_gnt)          perf_done_cnt  <= perf_done_cnt + 32'd1;
      if (fu.issue_valid & fu.issue_stall)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mult_fu_pipe.sv
// Scoreboard bench for mult_fu_pipe: the driver pushes expected {tag,result} on each
// accepted issue, a negedge monitor pops and compares on every CDB grant.
module tb_mult_fu_pipe;
  import mult_fu_pipe_pkg::*;

  logic clock;
  logic reset;
  logic squash;

  mult_fu_pipe_if bus ();

`ifdef MULT_FU_PERF_CNT_EN
  logic [31:0] perf_done_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  mult_fu_pipe dut (
    .clock (clock),
    .reset (reset),
    .squash(squash),
    .fu    (bus)
`ifdef MULT_FU_PERF_CNT_EN
    ,
    .perf_done_cnt (perf_done_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  logic [TAG_W+XLEN-1:0] exp_q [$];
  bit flush_pend = 1'b0;

  task automatic check(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: the mathematical product, halves picked by function.
  function automatic logic [63:0] ref_mul(input mult_func_t f, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [127:0]        u;
    logic signed [127:0] s;
    case (f)
      MUL_LO:    return a * b;
      MUL_HI_UU: begin u = {64'd0, a} * {64'd0, b};        return u[127:64]; end
      MUL_HI_SS: begin s = $signed(a) * $signed(b);        return s[127:64]; end
      default:   begin s = $signed(a) * $signed({1'b0, b}); return s[127:64]; end
    endcase
  endfunction

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic step(input bit v, input logic [63:0] a, input logic [63:0] b,
                      input mult_func_t f, input logic [TAG_W-1:0] tag, input bit gnt,
                      input bit sq, input bit use_exp = 1'b0, input logic [63:0] exp = '0);
    @(posedge clock);
    if (flush_pend) begin
      exp_q.delete();
      flush_pend = 1'b0;
    end
    #1;
    bus.issue_valid = v;
    bus.issue_opa   = a;
    bus.issue_opb   = b;
    bus.issue_func  = f;
    bus.issue_tag   = tag;
    bus.cdb_gnt     = gnt;
    squash          = sq;
    #1;
    if (sq) flush_pend = 1'b1;
    else if (v && !bus.issue_stall)
      exp_q.push_back({tag, use_exp ? exp : ref_mul(f, a, b)});
  endtask

  task automatic idle(input int n, input bit gnt);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, MUL_LO, '0, gnt, 1'b0);
  endtask

  // Monitor: one line per broadcast result; also checks done_* hold while ungranted.
  logic                  hold_vld = 1'b0;
  logic [TAG_W+XLEN-1:0] hold_val;
  always @(negedge clock) begin
    logic [TAG_W+XLEN-1:0] e;
    if (!reset) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld)
        check(bus.done_valid && {bus.done_tag, bus.done_result} == hold_val, "done_hold",
              {bus.done_valid, bus.done_tag, bus.done_result}, {1'b1, hold_val});
      hold_vld = bus.done_valid && !bus.cdb_gnt && !squash;
      hold_val = {bus.done_tag, bus.done_result};
      if (bus.done_valid && bus.cdb_gnt) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "spurious_done", {bus.done_tag, bus.done_result}, '0);
        end else begin
          e = exp_q.pop_front();
          check({bus.done_tag, bus.done_result} == e, "result",
                {bus.done_tag, bus.done_result}, e);
          $display("txn tag=%0d result=%h expected=%h", bus.done_tag, bus.done_result,
                   e[XLEN-1:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; squash = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_opa = '0; bus.issue_opb = '0;
    bus.issue_func = MUL_LO; bus.issue_tag = '0; bus.cdb_gnt = 1'b0;
    @(posedge clock); #2;
    check(bus.done_valid == 1'b0, "rst_done_valid", bus.done_valid, 0);
    check(bus.done_result == '0, "rst_done_result", bus.done_result, 0);
    check(bus.done_tag == '0, "rst_done_tag", bus.done_tag, 0);
    check(bus.issue_stall == 1'b0, "rst_issue_stall", bus.issue_stall, 0);
`ifdef MULT_FU_PERF_CNT_EN
    check(perf_done_cnt == 0, "rst_perf_done", perf_done_cnt, 0);
`endif
    @(posedge clock); #3 reset = 1'b1;

    // Single op, 4-cycle latency
    step(1'b1, 64'd3, 64'd5, MUL_LO, 6'd7, 1'b1, 1'b0, 1'b1, 64'd15);
    for (int i = 1; i <= 5; i++) begin
      idle(1, 1'b1);
      check(bus.done_valid == (i == 4), $sformatf("latency_c%0d", i), bus.done_valid, i == 4);
    end

    // Function corner values
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MUL_HI_SS, 6'd1, 1'b1, 1'b0,
         1'b1, 64'd0);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MUL_HI_UU, 6'd2, 1'b1, 1'b0,
         1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, MUL_HI_SU, 6'd3, 1'b1, 1'b0,
         1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, MUL_LO, 6'd4, 1'b1, 1'b0,
         1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    idle(6, 1'b1);

    // Back-pressure: 6 attempts with no grant, stall from the 5th
    for (int i = 0; i < 6; i++) begin
      step(1'b1, rnd_op(), rnd_op(), mult_func_t'($urandom_range(0, 3)), 6'(30 + i), 1'b0, 1'b0);
      check(bus.issue_stall == (i >= 4), $sformatf("bp_stall_%0d", i), bus.issue_stall, i >= 4);
    end
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b1);
      check(bus.done_valid == (i < 4), $sformatf("bp_drain_%0d", i), bus.done_valid, i < 4);
    end

    // Bubble collapse behind a stalled tail
    step(1'b1, 64'd9, 64'd9, MUL_LO, 6'd10, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 64'd4, 64'd4, MUL_LO, 6'd11, 1'b0, 1'b0);
    check(bus.issue_stall == 1'b0, "bubble_stall", bus.issue_stall, 0);
    idle(4, 1'b0);
    check(bus.done_valid && bus.done_tag == 6'd10, "bubble_tail_a",
          {bus.done_valid, bus.done_tag}, {1'b1, 6'd10});
    idle(1, 1'b1);
    idle(1, 1'b0);
    check(bus.done_valid && bus.done_tag == 6'd11, "bubble_b_next",
          {bus.done_valid, bus.done_tag}, {1'b1, 6'd11});
    idle(3, 1'b1);

    // Squash with 3 ops in flight plus an issue in the squash cycle
    for (int i = 0; i < 3; i++) step(1'b1, rnd_op(), rnd_op(), MUL_HI_UU, 6'(20 + i), 1'b0, 1'b0);
    step(1'b1, 64'd5, 64'd5, MUL_LO, 6'd23, 1'b0, 1'b1);
    idle(1, 1'b1);
    check(bus.done_valid == 1'b0, "squash_done_valid", bus.done_valid, 0);
    check(bus.issue_stall == 1'b0, "squash_stall", bus.issue_stall, 0);
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b1);
      check(bus.done_valid == 1'b0, $sformatf("squash_quiet_%0d", i), bus.done_valid, 0);
    end

    // Randomised traffic with grants, stalls and occasional squashes
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, rnd_op(), rnd_op(), mult_func_t'($urandom_range(0, 3)),
           TAG_W'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
    end
    idle(8, 1'b1);
    check(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);

    // Asynchronous reset mid-flight
    step(1'b1, 64'd6, 64'd7, MUL_LO, 6'd40, 1'b0, 1'b0);
    idle(4, 1'b0);
    check(bus.done_valid == 1'b1, "pre_reset_valid", bus.done_valid, 1);
    #1 reset = 1'b0;
    #1 check(bus.done_valid == 1'b0, "async_reset_valid", bus.done_valid, 0);
    exp_q.delete();
    flush_pend = 1'b0;
    @(posedge clock);
    @(posedge clock); #3 reset = 1'b1;
    idle(2, 1'b1);
    check(bus.done_valid == 1'b0, "post_reset_valid", bus.done_valid, 0);
`ifdef MULT_FU_PERF_CNT_EN
    check(perf_done_cnt == 0, "perf_done_after_reset", perf_done_cnt, 0);
`endif
    for (int i = 0; i < 10; i++)
      step(1'b1, rnd_op(), rnd_op(), mult_func_t'($urandom_range(0, 3)), 6'(50 + i), 1'b1, 1'b0);
    idle(6, 1'b1);
    check(exp_q.size() == 0, "final_empty", exp_q.size(), 0);
`ifdef MULT_FU_PERF_CNT_EN
    check(perf_done_cnt == 10, "perf_done_10", perf_done_cnt, 10);
    check(perf_stall_cnt == 0, "perf_stall_0", perf_stall_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
